// File: rtl/tpu_result_uart_tx.sv
// tpu_result_uart_tx
//   Captures TPU result bytes into a small FIFO and sends each one over a
//   UART TX line as an ASCII line: two uppercase hex digits, CR, LF (8N1).
//
// Parameters
//   CLK_HZ      input clock frequency in Hz
//   BAUD        UART bit rate; one bit lasts CLK_HZ/BAUD cycles
//   FIFO_DEPTH  result queue depth (power of 2, >= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   result_i     TPU result byte, sampled when capture_i=1
//   capture_i    one-cycle strobe pushing result_i into the FIFO
//   tx_o         registered UART output, idle high
//   busy_o       high while a 4-character line is on the wire
//   fifo_full_o  FIFO holds FIFO_DEPTH entries
//   drop_o       one-cycle pulse after a capture lost to a full FIFO
module tpu_result_uart_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result_i,
  input  logic       capture_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       fifo_full_o,
  output logic       drop_o
);

  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] RELOAD = CW'(BIT_CLKS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    // 'A' - 10 = 0x37
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // FIFO storage and control
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          full, empty, pop, push_ok;
  logic          drop_q;

  // Transmitter state
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    chr_q, chr_d;
  logic [7:0]    line_q;
  logic [7:0]    cur_char;
  logic          tx_q, tx_d;
  logic          busy_q;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign push_ok = capture_i && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      drop_q <= capture_i && full && !pop;
    end
  end

  // Storage is data-only; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= result_i;
  end

  always_ff @(posedge clk) begin
    if (pop) line_q <= mem[rd_q];
  end

  always_comb begin
    case (chr_q)
      2'd0:    cur_char = hex_ascii(line_q[7:4]);
      2'd1:    cur_char = hex_ascii(line_q[3:0]);
      2'd2:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    bit_d   = bit_q;
    chr_d   = chr_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = RELOAD;
        if (!empty) begin
          pop     = 1'b1;
          chr_d   = 2'd0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = cur_char[bit_q];
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (chr_q != 2'd3) begin
            chr_d   = chr_q + 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx/busy are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= RELOAD;
      bit_q   <= 3'd0;
      chr_q   <= 2'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign fifo_full_o = full;
  assign drop_o      = drop_q;

endmodule

// File: doc/tpu_result_uart_tx.md
# tpu_result_uart_tx

Result-readout block for the Mini-TPU board build. It reads the 8-bit `result` bus from `tpu` on a capture strobe and queues each byte in a small FIFO. It then serialises every byte over a UART TX line as an ASCII line: two uppercase hex digits, then CR LF. It sits beside the switch/button instruction path in the board top and is the host-facing read path for what the instruction path writes.

## Interface
- `CLK_HZ`, default 100_000_000, input clock frequency in Hz.
- `BAUD`, default 115200, UART bit rate. Bit period `BIT_CLKS = CLK_HZ / BAUD` (integer division; 868 at defaults).
- `FIFO_DEPTH`, default 4, result queue depth. Must be a power of 2 and at least 2.

- `clk`  in  1  system clock. Single clock domain; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `result_i`  in  8  TPU result byte, sampled only when `capture_i`=1.
- `capture_i`  in  1  single-cycle pulse: push `result_i` into the FIFO.
- `tx_o`  out  1  UART serial output, 8N1, idle high. Registered.
- `busy_o`  out  1  high while a line (4 characters) is being transmitted.
- `fifo_full_o`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `drop_o`  out  1  one-cycle pulse when a capture is discarded because the FIFO is full.

## Operation
- Reset values: `tx_o`=1, `busy_o`=0, `fifo_full_o`=0, `drop_o`=0. Reset also clears the FIFO and puts the FSM in IDLE.
- Reset mid-frame abandons the frame. `tx_o` is 1 on the cycle after reset is sampled, and no partial character resumes.
- FIFO push and pop:
  - Push happens on `capture_i`=1.
  - Pop happens when the FSM leaves IDLE.
  - A push while full is dropped and `drop_o` pulses, unless a pop occurs in the same cycle; then the push is accepted.
  - A push while empty with a simultaneous pop is impossible: IDLE pops only when the FIFO is non-empty.
- Line format per byte B: `hex(B[7:4])`, `hex(B[3:0])`, 0x0D, 0x0A.
  - `hex(n)` is 0x30+n for n≤9 and 0x41+(n−10) for n≥10.
- Character format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is exactly `BIT_CLKS` cycles.
- FSM states:
  - IDLE: `tx_o`=1, `busy_o`=0. If the FIFO is non-empty, pop into the line register, set char index = 0, go to START.
  - START: drive 0 for `BIT_CLKS`, then go to DATA with bit index 0.
  - DATA: drive the current char bit for `BIT_CLKS`. Increment the bit index; after bit 7 go to STOP.
  - STOP: drive 1 for `BIT_CLKS`. If char index < 3, increment it and go to START. Otherwise go to IDLE.
- `busy_o` is 1 in START, DATA and STOP.
- The baud counter reloads at every bit boundary. There is no fractional-baud accumulation.

## Timing
- Capture at edge N with FIFO empty and FSM in IDLE:
  - Entry visible at edge N+1; FSM pops at N+1.
  - `tx_o` falls and `busy_o` rises at edge N+2.
- Line duration: 40 × `BIT_CLKS` cycles, from the `tx_o` fall to the end of the LF stop bit (34 720 cycles at defaults).
- Back-to-back lines: after the LF stop bit the FSM spends exactly one cycle in IDLE (`tx_o`=1, `busy_o`=0). The next start bit begins on the following edge.
- `fifo_full_o` updates the cycle after the push or pop that changes the occupancy.
- `drop_o` asserts for exactly one cycle, the cycle after the dropped capture edge.
- Pop-side latency is independent of `result_i` after the capture edge. Only the sampled value is sent.

## Test plan
- Reset: hold `rst` 3 cycles mid-line → next cycle `tx_o`=1, `busy_o`=0, `fifo_full_o`=0, `drop_o`=0; no further start bit without a new capture.
- Single capture, `result_i`=0x3C → `tx_o` falls 2 cycles later; decoded chars are 0x33, 0x43, 0x0D, 0x0A; `busy_o` is high for exactly 40×`BIT_CLKS` cycles.
- Hex letters, `result_i`=0xAF then 0x09 → lines "AF\r\n" then "09\r\n", with exactly one idle-high cycle between them.
- Overflow: six consecutive single-cycle captures 0x01..0x06 from idle, `FIFO_DEPTH`=4 → 0x01 is popped immediately and 0x02..0x05 are queued; `fifo_full_o`=1; 0x06 is dropped with one `drop_o` pulse; output order is 01, 02, 03, 04, 05.
- Full with simultaneous pop: fill the FIFO during a line and issue a capture on the exact cycle the FSM pops → capture accepted, no `drop_o`.
- Bit timing with `CLK_HZ`=1000, `BAUD`=100 → every bit is exactly 10 cycles and each line is 400 cycles; check every `tx_o` edge position for `result_i`=0x55.
